gtech_tt_sweep: RTL and testbench
=================================

# gtech_tt_sweep

Sequential truth-table sweeper for 4-input GTECH combinational cells.
- Drives every input vector into a cell under test, waits a programmable settle interval, samples the cell output and compares it against an expected truth table.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside the GTECH cell library as the checking end of the cell's input→output contract, and serves as a built-in self-test wrapper around any single-output GTECH gate.

## Interface
Parameters:
- N_IN, 4, number of cell inputs; the sweep covers 2^N_IN vectors.
- SETTLE, 2, cycles each vector is held before `DUT_Z` is sampled (≥1).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a sweep; honoured only in IDLE.
- EXP  in  2^N_IN  expected truth table; bit i is the expected `DUT_Z` for vector i; latched on the accepted START.
- DUT_IN  out  N_IN  vector driven to the cell; bit 0 is the cell's first input.
- DUT_Z  in  1  cell output under test.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse at sweep completion.
- PASS  out  1  last completed sweep had zero mismatches.
- ERR_CNT  out  N_IN+1  mismatch count of the current or last sweep.
- FAIL_IDX  out  N_IN  index of the first mismatching vector; 0 when none.

## Operation
- States: IDLE and RUN.
- IDLE → RUN when START=1 at an edge. On that same edge:
  - latch EXP;
  - set DUT_IN=0;
  - load the settle counter with SETTLE-1;
  - clear ERR_CNT, FAIL_IDX and PASS;
  - raise BUSY.
- In RUN, each edge does one of two things:
  - Counter ≠ 0: decrement it.
  - Counter = 0: sample DUT_Z and compare it to EXP_latched[DUT_IN].
    - On mismatch, increment ERR_CNT. If this is the first mismatch, FAIL_IDX ← DUT_IN.
    - If DUT_IN ≠ 2^N_IN-1: increment DUT_IN and reload the counter.
    - Otherwise: go to IDLE, BUSY=0, DONE=1 for one cycle, PASS ← (final ERR_CNT == 0), including the last comparison.
- START while BUSY is ignored; it is neither queued nor does it restart the sweep.
- START in the DONE cycle (state IDLE) is accepted normally, so back-to-back sweeps are possible.
- ERR_CNT cannot overflow because it is N_IN+1 bits wide and at most 2^N_IN mismatches occur. No saturation logic.
- Results (PASS, ERR_CNT, FAIL_IDX) hold until the next accepted START or reset.
- DUT_IN holds its last value (2^N_IN-1) in IDLE after a sweep.
- A change on EXP during RUN has no effect.

## Timing
- Reset values:
  - state IDLE;
  - DUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_IDX=0;
  - counter=0.
- RST asserted mid-sweep aborts immediately to these values. No DONE is produced and results are lost.
- START accepted at edge e0; vector i is driven from edge e0+i·SETTLE.
- DUT_Z for vector i is sampled at edge e0+(i+1)·SETTLE, so the cell has SETTLE full cycles of setup.
- Last sample at e0+2^N_IN·SETTLE. DONE is high and BUSY low in the cycle following that edge.
- Sweep latency: 2^N_IN·SETTLE cycles from the accept edge. Default is 32 cycles.
- All outputs are registered; no combinational path from DUT_Z or START to any output.

## Structure
- Package `gtech_tt_pkg` holds:
  - the state enum (IDLE, RUN);
  - default SETTLE and N_IN constants;
  - a width helper for ERR_CNT (N_IN+1).
- One sub-module, `gtech_tt_settle_cnt`:
  - loadable down-counter, width clog2(SETTLE);
  - inputs load/enable;
  - output zero flag;
  - handles SETTLE=1 with a constant-zero flag.
- Top level contains the FSM, vector register, expected-table latch and result registers.

## Test plan
- NAND4 model as DUT (DUT_Z = ~&DUT_IN), EXP=16'h7FFF, SETTLE=2, START at e0 → DUT_IN steps 0..15 every 2 cycles; DONE at cycle after e0+32; PASS=1, ERR_CNT=0, FAIL_IDX=0.
- Same DUT, EXP=16'h7FDF (bit 5 flipped) → ERR_CNT=1, FAIL_IDX=5, PASS=0.
- DUT_Z stuck at 0, EXP=16'h7FFF → ERR_CNT=15, FAIL_IDX=0, PASS=0.
- START pulsed at e0+7 during a sweep, and EXP changed at e0+9 → ignored; DONE still at e0+32+1 with the original EXP result.
- RST asserted at e0+11 (async, mid-cycle) → all outputs 0 immediately, no DONE. A new START after release gives a full 32-cycle sweep from DUT_IN=0.
- SETTLE=1, START held high continuously → sweeps of 16 cycles back-to-back. Each DONE cycle also accepts the next START, and ERR_CNT clears on every restart.

Source files
------------

// File: rtl/gtech_tt_pkg.sv
// Shared types and constants for the GTECH truth-table sweeper.
package gtech_tt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 2;

  // One extra bit so a sweep where every vector mismatches still fits.
  function automatic int err_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/gtech_tt_settle_cnt.sv
// Loadable settle down-counter; zero flags the cycle in which DUT_Z is sampled.
module gtech_tt_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  generate
    if (SETTLE == 1) begin : g_one
      // Every RUN edge is a sample edge, so no state is needed.
      logic unused_in;
      assign unused_in = clk ^ rst ^ load ^ en;
      assign zero      = 1'b1;
    end else begin : g_cnt
      localparam int W = $clog2(SETTLE);
      logic [W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (load)             cnt <= W'(SETTLE - 1);
        else if (en && cnt != '0)  cnt <= cnt - W'(1);
      end

      assign zero = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/gtech_tt_sweep.sv
// Sweeps every input vector into a single-output GTECH cell and checks DUT_Z
// against a latched expected truth table.
module gtech_tt_sweep
  import gtech_tt_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [(1<<N_IN)-1:0]     EXP,
  output logic [N_IN-1:0]          DUT_IN,
  input  logic                     DUT_Z,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     PASS,
  output logic [err_w(N_IN)-1:0]   ERR_CNT,
  output logic [N_IN-1:0]          FAIL_IDX
);

  localparam int EW = err_w(N_IN);

  state_t                state, state_d;
  logic [(1<<N_IN)-1:0]  exp_q;
  logic                  zero, accept, sample, last, mismatch, cnt_load;

  assign accept   = (state == IDLE) && START;
  assign sample   = (state == RUN) && zero;
  assign last     = (DUT_IN == '1);
  assign mismatch = (DUT_Z != exp_q[DUT_IN]);
  assign cnt_load = accept || (sample && !last);

  gtech_tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk  (CLK),
    .rst  (RST),
    .load (cnt_load),
    .en   (state == RUN),
    .zero (zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (START)        state_d = RUN;
      RUN:     if (zero && last) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q    <= '0;
      DUT_IN   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_IDX <= '0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        exp_q    <= EXP;
        DUT_IN   <= '0;
        BUSY     <= 1'b1;
        PASS     <= 1'b0;
        ERR_CNT  <= '0;
        FAIL_IDX <= '0;
      end else if (sample) begin
        if (mismatch) begin
          ERR_CNT <= ERR_CNT + EW'(1);
          // A zero count means this is the first mismatch of the sweep.
          if (ERR_CNT == '0) FAIL_IDX <= DUT_IN;
        end
        if (!last) begin
          DUT_IN <= DUT_IN + N_IN'(1);
        end else begin
          BUSY <= 1'b0;
          DONE <= 1'b1;
          PASS <= (ERR_CNT == '0) && !mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_gtech_tt_sweep.sv
// Directed bench: NAND4 cell model, scoreboard of expected sweep results.
module tb_gtech_tt_sweep;

  typedef struct {
    logic [4:0] err;
    logic [3:0] fidx;
    logic       pass;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0, stuck = 1'b0;
  logic [15:0] exp_t = 16'h0;
  logic [3:0]  dut_in, fail_idx;
  logic        dut_z, busy, done, pass;
  logic [4:0]  err_cnt;

  logic        start1 = 1'b0;
  logic [15:0] exp_t1 = 16'h0;
  logic [3:0]  dut_in1, fail_idx1;
  logic        dut_z1, busy1, done1, pass1;
  logic [4:0]  err_cnt1;

  int n_vec = 0;
  int n_err = 0;
  res_t sb[$];
  res_t sb1[$];

  always #5 clk = ~clk;

  assign dut_z  = stuck ? 1'b0 : ~&dut_in;
  assign dut_z1 = ~&dut_in1;

  gtech_tt_sweep #(.N_IN(4), .SETTLE(2)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .EXP(exp_t), .DUT_IN(dut_in),
    .DUT_Z(dut_z), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .FAIL_IDX(fail_idx)
  );

  gtech_tt_sweep #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .EXP(exp_t1), .DUT_IN(dut_in1),
    .DUT_Z(dut_z1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err_cnt1), .FAIL_IDX(fail_idx1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [15:0] e, input bit stk);
    res_t r;
    logic [3:0] v;
    logic z;
    r.err = '0; r.fidx = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      z = stk ? 1'b0 : ~&v;
      if (z !== e[i]) begin
        if (r.err == 0) r.fidx = v;
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic pop_check(input string tag);
    res_t r;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      r = sb.pop_front();
      chk({tag, "_err"},  32'(err_cnt),  32'(r.err));
      chk({tag, "_fidx"}, 32'(fail_idx), 32'(r.fidx));
      chk({tag, "_pass"}, 32'(pass),     32'(r.pass));
    end
  endtask

  // One SETTLE=2 sweep; inject pulses START mid-sweep and changes EXP.
  task automatic sweep(input string tag, input logic [15:0] e, input bit inject);
    int done_at;
    sb.push_back(model(e, stuck));
    exp_t = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_in0"},   32'(dut_in), 32'd0);
    chk({tag, "_clr"},   32'({err_cnt, fail_idx, pass}), 32'd0);
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin done_at = k; break; end
      if (k % 2 == 0) chk({tag, "_vec"}, 32'(dut_in), 32'(k / 2));
      if (inject && k == 6) start = 1'b1;
      if (inject && k == 7) start = 1'b0;
      if (inject && k == 8) exp_t = ~e;
    end
    chk({tag, "_done_at"}, 32'(done_at), 32'd32);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_in_end"}, 32'(dut_in), 32'd15);
    pop_check(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold_err"}, 32'(err_cnt), 32'(model(e, stuck).err));
  endtask

  initial begin
    int n_done, gap;
    res_t r;
    #12;
    chk("rst_state0", 32'({dut_in, busy, done, pass, err_cnt, fail_idx}), 32'd0);
    chk("rst_state1", 32'({dut_in1, busy1, done1, pass1, err_cnt1, fail_idx1}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    sweep("nand_ok",  16'h7FFF, 1'b0);
    sweep("bit5",     16'h7FDF, 1'b0);
    stuck = 1'b1;
    sweep("stuck0",   16'h7FFF, 1'b0);
    stuck = 1'b0;
    sweep("ignore",   16'h7FDF, 1'b1);

    // Asynchronous reset in the middle of a sweep.
    sb.push_back(model(16'h7FFF, 1'b0));
    exp_t = 16'h7FFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    chk("abort_outs", 32'({dut_in, busy, done, pass, err_cnt, fail_idx}), 32'd0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) n_done++; end
    chk("abort_no_done", 32'(n_done), 32'd0);
    sweep("after_rst", 16'h7FFF, 1'b0);

    // SETTLE=1, START held: back-to-back sweeps, 16 cycles each plus the DONE cycle.
    exp_t1 = 16'h0000;
    start1 = 1'b1;
    sb1.push_back(model(16'h0000, 1'b0));
    @(posedge clk); #1;
    chk("s1_busy0", 32'(busy1), 32'd1);
    for (int s = 0; s < 3; s++) begin
      gap = -1;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk); #1;
        if (done1) begin gap = k; break; end
        chk("s1_vec", 32'(dut_in1), 32'(k));
      end
      chk("s1_done_at", 32'(gap), 32'd16);
      if (sb1.size() == 0) begin
        chk("s1_sb_empty", 32'(sb1.size()), 32'd1);
      end else begin
        r = sb1.pop_front();
        chk("s1_err",  32'(err_cnt1),  32'(r.err));
        chk("s1_fidx", 32'(fail_idx1), 32'(r.fidx));
        chk("s1_pass", 32'(pass1),     32'(r.pass));
      end
      sb1.push_back(model(16'h0000, 1'b0));
      @(posedge clk); #1;
      chk("s1_restart", 32'({busy1, dut_in1, err_cnt1}), 32'({1'b1, 4'd0, 5'd0}));
    end
    start1 = 1'b0;
    sb1.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
